// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants: default register-file geometry and the hard-wired zero register.
package cpu_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 3;
   localparam int ZERO_REG   = 0;

endpackage : cpu_pkg

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on accepted issue,
// cleared on writeback, with a WAW stall on issue to a still-pending register.
module reg_scoreboard
   import cpu_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter bit R0_ZERO = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 iss_en,
   input  logic [ADDR_W-1:0]    iss_addr,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   output logic                 iss_ready,
   output logic [2**ADDR_W-1:0] busy_vec
);

   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

   logic                 iss_acc;
   logic [2**ADDR_W-1:0] busy_nxt;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      busy_nxt  = busy_vec;
      iss_ready = !busy_vec[iss_addr] || (wr_en && (wr_addr == iss_addr));
      iss_acc   = iss_en && iss_ready && !(R0_ZERO && (iss_addr == ZERO_IDX));
      // Issue is applied after release so a same-cycle re-issue keeps the bit set.
      if (wr_en)
         busy_nxt[wr_addr] = 1'b0;
      if (iss_acc)
         busy_nxt[iss_addr] = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         busy_vec <= '0;
      else
         busy_vec <= busy_nxt;
   end

endmodule : reg_scoreboard

// File: rtl/reg_file_sb.sv
// Two-read, one-write register file with byte enables, optional zero register,
// optional write-to-read bypass, and an issue/writeback scoreboard.
module reg_file_sb
   import cpu_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ADDR_W  = ADDR_W_DEF,
   parameter bit R0_ZERO = 1'b1,
   parameter bit BYPASS  = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [ADDR_W-1:0]    rd_addr_a,
   input  logic [ADDR_W-1:0]    rd_addr_b,
   output logic [DATA_W-1:0]    rd_data_a,
   output logic [DATA_W-1:0]    rd_data_b,
   output logic                 rd_busy_a,
   output logic                 rd_busy_b,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic [DATA_W/8-1:0]  wr_be,
   input  logic                 iss_en,
   input  logic [ADDR_W-1:0]    iss_addr,
   output logic                 iss_ready,
   output logic [2**ADDR_W-1:0] busy_vec
);

   localparam int                DEPTH    = 2**ADDR_W;
   localparam int                NB       = DATA_W/8;
   localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

   logic [DATA_W-1:0] regs [DEPTH];
   logic              wr_ok;
   logic              hit_a;
   logic              hit_b;

   assign wr_ok = wr_en && !(R0_ZERO && (wr_addr == ZERO_IDX));
   assign hit_a = BYPASS && wr_ok && (rd_addr_a == wr_addr);
   assign hit_b = BYPASS && wr_ok && (rd_addr_b == wr_addr);

   reg_scoreboard #(
      .ADDR_W  (ADDR_W),
      .R0_ZERO (R0_ZERO)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .iss_en    (iss_en),
      .iss_addr  (iss_addr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .iss_ready (iss_ready),
      .busy_vec  (busy_vec)
   );

   // NOTE: the array is reset on purpose (contents must clear asynchronously), so it maps to flops, not RAM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
      end else if (wr_ok) begin
         for (int k = 0; k < NB; k++)
            if (wr_be[k])
               regs[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
      end
   end

   function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] stored,
                                                     input logic              hit,
                                                     input logic [DATA_W-1:0] wdata,
                                                     input logic [NB-1:0]     be);
      logic [DATA_W-1:0] res;
      res = stored;
      for (int k = 0; k < NB; k++)
         if (hit && be[k])
            res[8*k +: 8] = wdata[8*k +: 8];
      return res;
   endfunction

   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      rd_busy_a = 1'b0;
      rd_busy_b = 1'b0;
      // Outputs sit at their reset values for the whole reset window, bypass included.
      if (!reset) begin
         if (!(R0_ZERO && (rd_addr_a == ZERO_IDX)))
            rd_data_a = merge_bytes(regs[rd_addr_a], hit_a, wr_data, wr_be);
         if (!(R0_ZERO && (rd_addr_b == ZERO_IDX)))
            rd_data_b = merge_bytes(regs[rd_addr_b], hit_b, wr_data, wr_be);
         rd_busy_a = busy_vec[rd_addr_a] && !hit_a;
         rd_busy_b = busy_vec[rd_addr_b] && !hit_b;
      end
   end

endmodule : reg_file_sb
